// File: rtl/digit_scan_ctrl.sv
// digit_scan_ctrl: time-multiplexed digit scanner with per-slot blanking and digit masking
module digit_scan_ctrl #(
    parameter int N_DIGITS   = 4,
    parameter int IDX_W      = 2,
    parameter int DIV        = 50000,
    parameter int BLANK      = 2,
    parameter bit ACTIVE_LOW = 1
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_en,
    input  logic [N_DIGITS-1:0] i_mask,
    output logic [IDX_W-1:0]    o_ctrl,
    output logic [N_DIGITS-1:0] o_digitSelect,
    output logic                o_blank,
    output logic                o_tick
);
    localparam int CNT_W = $clog2(DIV);
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [IDX_W-1:0]    idx_q, idx_d, idx_nxt;
    logic                en_q;
    logic [N_DIGITS-1:0] mask_q;
    logic                found;
    logic                tick;
    logic                active;
    logic [N_DIGITS-1:0] onehot;
    // Slot counter, current digit and the registered copies of the inputs
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            cnt_q  <= '0;
            idx_q  <= '0;
            en_q   <= 1'b0;
            mask_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            idx_q  <= idx_d;
            en_q   <= i_en;
            mask_q <= i_mask;
        end
    end
    // Next enabled digit after the current one, ascending with wrap; holds when none other is enabled
    always_comb begin
        idx_nxt = idx_q;
        found   = 1'b0;
        for (int k = 1; k < N_DIGITS; k++) begin
            if (!found && mask_q[(int'(idx_q) + k) % N_DIGITS]) begin
                idx_nxt = IDX_W'((int'(idx_q) + k) % N_DIGITS);
                found   = 1'b1;
            end
        end
    end
    // Counter wraps at the slot end and is parked at zero while disabled; digit advances on the tick
    always_comb begin
        tick  = en_q && (cnt_q == CNT_W'(DIV - 1));
        cnt_d = (!en_q || tick) ? '0 : cnt_q + 1'b1;
        idx_d = tick ? idx_nxt : idx_q;
    end
    // Output decode from registers only; blanking window hides the digit at the start of each slot
    always_comb begin
        active        = en_q && (cnt_q >= CNT_W'(BLANK)) && mask_q[idx_q];
        onehot        = active ? (N_DIGITS'(1) << idx_q) : '0;
        o_digitSelect = ACTIVE_LOW ? ~onehot : onehot;
        o_blank       = !active;
        o_tick        = tick;
        o_ctrl        = idx_q;
    end
endmodule

// File: tb/tb_digit_scan_ctrl.sv
// tb_digit_scan_ctrl: randomized scoreboard bench for digit_scan_ctrl against a slot-level model
module tb_digit_scan_ctrl;
    localparam int N = 4;
    localparam int DIV = 8;
    localparam int BLANK = 2;

    typedef struct packed {
        logic [1:0] ctrl;
        logic [3:0] sel;
        logic       blank;
        logic       tick;
    } exp_t;

    logic       i_clk = 1'b0;
    logic       i_rst = 1'b1;
    logic       i_en = 1'b0;
    logic [3:0] i_mask = '0;
    logic [1:0] o_ctrl, h_ctrl;
    logic [3:0] o_sel, h_sel;
    logic       o_blank, h_blank, o_tick, h_tick;

    exp_t q[$];
    int   n_vec = 0;
    int   n_err = 0;

    int         m_pos = 0;
    int         m_dig = 0;
    bit         m_en = 1'b0;
    logic [3:0] m_mask = '0;

    digit_scan_ctrl #(.N_DIGITS(N), .IDX_W(2), .DIV(DIV), .BLANK(BLANK), .ACTIVE_LOW(1)) dut (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_mask(i_mask),
        .o_ctrl(o_ctrl), .o_digitSelect(o_sel), .o_blank(o_blank), .o_tick(o_tick)
    );

    digit_scan_ctrl #(.N_DIGITS(N), .IDX_W(2), .DIV(DIV), .BLANK(BLANK), .ACTIVE_LOW(0)) dut_h (
        .i_clk(i_clk), .i_rst(i_rst), .i_en(i_en), .i_mask(i_mask),
        .o_ctrl(h_ctrl), .o_digitSelect(h_sel), .o_blank(h_blank), .o_tick(h_tick)
    );

    always #5 i_clk = ~i_clk;

    function automatic int next_dig(input int d, input logic [3:0] m);
        for (int k = 1; k < N; k++)
            if (m[(d + k) % N]) return (d + k) % N;
        return d;
    endfunction

    task automatic apply(input bit rst, input bit en, input logic [3:0] mask);
        exp_t       e;
        bit         act;
        logic [3:0] oh;
        @(negedge i_clk);
        i_rst  = rst;
        i_en   = en;
        i_mask = mask;
        if (rst) begin
            m_pos  = 0;
            m_dig  = 0;
            m_en   = 1'b0;
            m_mask = '0;
        end else begin
            if (m_en && m_pos == DIV - 1) m_dig = next_dig(m_dig, m_mask);
            m_pos  = m_en ? (m_pos + 1) % DIV : 0;
            m_en   = en;
            m_mask = mask;
        end
        act     = m_en && m_pos >= BLANK && m_mask[m_dig];
        oh      = 4'(1 << m_dig);
        e.ctrl  = 2'(m_dig);
        e.sel   = act ? ~oh : 4'hF;
        e.blank = !act;
        e.tick  = m_en && m_pos == DIV - 1;
        q.push_back(e);
    endtask

    initial begin
        exp_t e;
        forever begin
            @(posedge i_clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                n_vec++;
                if (o_ctrl !== e.ctrl) begin
                    n_err++;
                    $display("FAIL ctrl t=%0t got %b want %b", $time, o_ctrl, e.ctrl);
                end
                if (o_sel !== e.sel) begin
                    n_err++;
                    $display("FAIL sel t=%0t got %b want %b", $time, o_sel, e.sel);
                end
                if (o_blank !== e.blank) begin
                    n_err++;
                    $display("FAIL blank t=%0t got %b want %b", $time, o_blank, e.blank);
                end
                if (o_tick !== e.tick) begin
                    n_err++;
                    $display("FAIL tick t=%0t got %b want %b", $time, o_tick, e.tick);
                end
                if (h_sel !== ~e.sel) begin
                    n_err++;
                    $display("FAIL sel_active_high t=%0t got %b want %b", $time, h_sel, ~e.sel);
                end
            end
        end
    end

    initial begin
        logic [3:0] mask;
        repeat (2) apply(1'b1, 1'b0, 4'h0);
        repeat (40) apply(1'b0, 1'b1, 4'hF);
        repeat (40) apply(1'b0, 1'b1, 4'b0101);
        repeat (20) apply(1'b0, 1'b1, 4'b0000);
        apply(1'b1, 1'b0, 4'h0);
        for (int i = 0; i < 100 && !(m_dig == 2 && m_pos == 5); i++) apply(1'b0, 1'b1, 4'hF);
        repeat (6) apply(1'b0, 1'b0, 4'hF);
        repeat (12) apply(1'b0, 1'b1, 4'hF);
        for (int i = 0; i < 100 && !(m_dig == 3 && m_pos == 4); i++) apply(1'b0, 1'b1, 4'hF);
        apply(1'b1, 1'b1, 4'hF);
        repeat (20) apply(1'b0, 1'b1, 4'hF);
        mask = 4'hF;
        repeat (600) begin
            if ($urandom_range(0, 15) == 0) mask = 4'($urandom_range(0, 15));
            apply($urandom_range(0, 99) == 0, $urandom_range(0, 9) != 0, mask);
        end
        repeat (3) @(negedge i_clk);
        if (q.size() != 0 || n_vec == 0) begin
            n_err++;
            $display("FAIL drain pending=%0d checked=%0d want pending=0 checked>0", q.size(), n_vec);
        end
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
